// File: rtl/branch_trace_recorder.sv
// Branch trace recorder: captures {address, actual, predicted} per resolved branch into
// an on-chip buffer, keeps saturating branch/mispredict statistics, then drains the
// buffer in capture order over a valid/ready port. Once the drain finishes, the block
// holds its results in HALT until a clear pulse returns it to CAPTURE.
module branch_trace_recorder #(
  parameter int ADDRESS_SIZE = 8,
  parameter int DEPTH        = 1024,
  parameter int COUNT_WIDTH  = 32,
  parameter int PTR_WIDTH    = $clog2(DEPTH + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [ADDRESS_SIZE-1:0] in_address,
  input  logic                    in_actual,
  input  logic                    in_predicted,
  input  logic                    drain_req,
  input  logic                    clear,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDRESS_SIZE-1:0] out_address,
  output logic                    out_actual,
  output logic                    out_predicted,
  output logic [PTR_WIDTH-1:0]    entries,
  output logic [COUNT_WIDTH-1:0]  branch_count,
  output logic [COUNT_WIDTH-1:0]  mispredict_count,
  output logic                    overflow,
  output logic                    done
);

  // The memory index only has to address DEPTH slots. The entry count needs one extra
  // value so that it can represent a full buffer.
  localparam int IDX_WIDTH   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int ENTRY_WIDTH = ADDRESS_SIZE + 2;

  typedef enum logic [1:0] {
    CAPTURE = 2'd0,
    DRAIN   = 2'd1,
    HALT    = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [ENTRY_WIDTH-1:0] mem [DEPTH];
  logic [IDX_WIDTH-1:0]   wr_ptr;
  logic [IDX_WIDTH-1:0]   rd_ptr;
  logic [IDX_WIDTH-1:0]   rd_ptr_next;
  logic                   ready_en;
  logic                   read_armed;
  logic                   full;
  logic                   capture;
  logic                   drop;
  logic                   accept;
  logic                   last_entry;

  // ready_en keeps in_ready low while reset is held. It releases one cycle after reset
  // is deasserted.
  assign full        = (entries == PTR_WIDTH'(DEPTH));
  assign in_ready    = ready_en && (state == CAPTURE) && !full;
  assign capture     = in_valid && in_ready;
  assign drop        = ready_en && (state == CAPTURE) && in_valid && full;
  assign accept      = (state == DRAIN) && out_valid && out_ready;
  assign last_entry  = (PTR_WIDTH'(rd_ptr) == entries - PTR_WIDTH'(1));
  assign rd_ptr_next = rd_ptr + IDX_WIDTH'(1);
  assign done        = (state == HALT);

  // State register; synchronous active-low reset returns to CAPTURE and aborts any drain.
  always_ff @(posedge clk) begin
    if (!reset) state <= CAPTURE;
    else        state <= state_next;
  end

  // Next-state logic: capture until drain_req, drain until the last entry is taken, then
  // wait in HALT for clear.
  always_comb begin
    state_next = state;
    case (state)
      CAPTURE: if (drain_req) state_next = DRAIN;
      DRAIN:   if ((entries == '0) || (accept && last_entry)) state_next = HALT;
      HALT:    if (clear) state_next = CAPTURE;
      default: state_next = CAPTURE;
    endcase
  end

  // Trace storage: write-only during capture, with no reset so that it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {in_address, in_actual, in_predicted};
  end

  // Datapath. In CAPTURE it maintains the pointers and the saturating statistics.
  // In DRAIN the output register is the synchronous memory read. It waits one priming
  // cycle before the first load, then reloads directly on each accepted handshake so
  // that entries can stream back to back.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ready_en         <= 1'b0;
      wr_ptr           <= '0;
      rd_ptr           <= '0;
      entries          <= '0;
      branch_count     <= '0;
      mispredict_count <= '0;
      overflow         <= 1'b0;
      read_armed       <= 1'b0;
      out_valid        <= 1'b0;
      out_address      <= '0;
      out_actual       <= 1'b0;
      out_predicted    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case (state)
        CAPTURE: begin
          if (capture) begin
            wr_ptr  <= wr_ptr + IDX_WIDTH'(1);
            entries <= entries + PTR_WIDTH'(1);
            if (branch_count != '1)
              branch_count <= branch_count + COUNT_WIDTH'(1);
            if ((in_actual != in_predicted) && (mispredict_count != '1))
              mispredict_count <= mispredict_count + COUNT_WIDTH'(1);
          end
          if (drop) overflow <= 1'b1;
          if (drain_req) begin
            rd_ptr     <= '0;
            read_armed <= 1'b0;
          end
        end
        DRAIN: begin
          if (!read_armed) begin
            read_armed <= 1'b1;
          end else if (!out_valid) begin
            {out_address, out_actual, out_predicted} <= mem[rd_ptr];
            out_valid <= 1'b1;
          end else if (out_ready) begin
            rd_ptr <= rd_ptr_next;
            if (last_entry) out_valid <= 1'b0;
            else            {out_address, out_actual, out_predicted} <= mem[rd_ptr_next];
          end
        end
        HALT: begin
          if (clear) begin
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            entries          <= '0;
            branch_count     <= '0;
            mispredict_count <= '0;
            overflow         <= 1'b0;
            read_armed       <= 1'b0;
            out_valid        <= 1'b0;
            out_address      <= '0;
            out_actual       <= 1'b0;
            out_predicted    <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_trace_recorder.sv
// Directed bench for branch_trace_recorder. A DEPTH=4 instance ("s_") exercises capture,
// overflow, stalled drain and clear. A default-depth instance ("b_") shares the same
// inputs and is used for the mid-drain reset sequence, which needs five entries.
module tb_branch_trace_recorder;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [7:0]  in_address;
  logic        in_actual;
  logic        in_predicted;
  logic        drain_req;
  logic        clear;
  logic        out_ready;

  logic        s_in_ready, s_out_valid, s_out_actual, s_out_predicted, s_overflow, s_done;
  logic [7:0]  s_out_address;
  logic [2:0]  s_entries;
  logic [31:0] s_branch_count, s_mispredict_count;

  logic        b_in_ready, b_out_valid, b_out_actual, b_out_predicted, b_overflow, b_done;
  logic [7:0]  b_out_address;
  logic [10:0] b_entries;
  logic [31:0] b_branch_count, b_mispredict_count;

  int pass_count  = 0;
  int fail_count  = 0;
  int check_count = 0;

  // Free-running clock with a 10-unit period.
  always #5 clk = ~clk;

  branch_trace_recorder #(.ADDRESS_SIZE(8), .DEPTH(4), .COUNT_WIDTH(32)) dut_small (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_address(in_address), .in_actual(in_actual), .in_predicted(in_predicted),
    .drain_req(drain_req), .clear(clear), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_address(s_out_address), .out_actual(s_out_actual), .out_predicted(s_out_predicted),
    .entries(s_entries), .branch_count(s_branch_count),
    .mispredict_count(s_mispredict_count), .overflow(s_overflow), .done(s_done)
  );

  branch_trace_recorder dut_big (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_address(in_address), .in_actual(in_actual), .in_predicted(in_predicted),
    .drain_req(drain_req), .clear(clear), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_address(b_out_address), .out_actual(b_out_actual), .out_predicted(b_out_predicted),
    .entries(b_entries), .branch_count(b_branch_count),
    .mispredict_count(b_mispredict_count), .overflow(b_overflow), .done(b_done)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic valid, input logic [7:0] addr,
                               input logic act, input logic pred);
    in_valid     = valid;
    in_address   = addr;
    in_actual    = act;
    in_predicted = pred;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    check_count++;
    assert (observed === expected) pass_count++;
    else begin
      fail_count++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    reset = 1'b0;
    drain_req = 1'b0;
    clear = 1'b0;
    out_ready = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);

    // Reset state
    tick();
    tick();
    checkOutput("rst_in_ready", s_in_ready, 1'b0);
    checkOutput("rst_out_valid", s_out_valid, 1'b0);
    checkOutput("rst_entries", s_entries, 3'd0);
    checkOutput("rst_branch", s_branch_count, 32'd0);
    checkOutput("rst_done", s_done, 1'b0);
    checkOutput("rst_overflow", s_overflow, 1'b0);
    checkOutput("rst_b_entries", b_entries, 11'd0);
    reset = 1'b1;
    tick();
    checkOutput("post_rst_in_ready", s_in_ready, 1'b1);

    // Test 1: three captures, then an in-order drain
    applyStimulus(1'b1, 8'h10, 1'b1, 1'b1); tick();
    applyStimulus(1'b1, 8'h22, 1'b0, 1'b1); tick();
    applyStimulus(1'b1, 8'h35, 1'b1, 1'b0); tick();
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t1_entries", s_entries, 3'd3);
    checkOutput("t1_branch", s_branch_count, 32'd3);
    checkOutput("t1_mispredict", s_mispredict_count, 32'd2);
    drain_req = 1'b1;
    out_ready = 1'b1;
    tick();
    drain_req = 1'b0;
    checkOutput("t1_lat0_valid", s_out_valid, 1'b0);
    tick();
    checkOutput("t1_lat1_valid", s_out_valid, 1'b0);
    tick();
    checkOutput("t1_e0_valid", s_out_valid, 1'b1);
    checkOutput("t1_e0_payload", {s_out_address, s_out_actual, s_out_predicted}, {8'h10, 2'b11});
    tick();
    checkOutput("t1_e1_payload", {s_out_address, s_out_actual, s_out_predicted}, {8'h22, 2'b01});
    tick();
    checkOutput("t1_e2_payload", {s_out_address, s_out_actual, s_out_predicted}, {8'h35, 2'b10});
    checkOutput("t1_e2_done", s_done, 1'b0);
    tick();
    checkOutput("t1_end_valid", s_out_valid, 1'b0);
    checkOutput("t1_done", s_done, 1'b1);
    checkOutput("t1_halt_branch", s_branch_count, 32'd3);
    checkOutput("t1_halt_entries", s_entries, 3'd3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("t1_clr_in_ready", s_in_ready, 1'b1);
    checkOutput("t1_clr_entries", s_entries, 3'd0);
    checkOutput("t1_clr_branch", s_branch_count, 32'd0);
    checkOutput("t1_clr_done", s_done, 1'b0);

    // Test 2: six back-to-back requests into a 4-deep buffer
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'hA0 + 8'(i), i[0], 1'b0);
      tick();
      checkOutput("t2_in_ready", s_in_ready, (i < 3));
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t2_entries", s_entries, 3'd4);
    checkOutput("t2_overflow", s_overflow, 1'b1);
    checkOutput("t2_branch", s_branch_count, 32'd4);
    checkOutput("t2_mispredict", s_mispredict_count, 32'd2);

    // Test 3: drain the four entries while out_ready toggles 1,0,0,1
    drain_req = 1'b1;
    out_ready = 1'b0;
    tick();
    drain_req = 1'b0;
    checkOutput("t3_lat0_valid", s_out_valid, 1'b0);
    checkOutput("t3_drain_in_ready", s_in_ready, 1'b0);
    tick();
    checkOutput("t3_lat1_valid", s_out_valid, 1'b0);
    tick();
    checkOutput("t3_e0_valid", s_out_valid, 1'b1);
    checkOutput("t3_e0_addr", s_out_address, 8'hA0);
    out_ready = 1'b1; tick();
    checkOutput("t3_e1_addr", s_out_address, 8'hA1);
    checkOutput("t3_e1_actual", s_out_actual, 1'b1);
    out_ready = 1'b0; tick();
    checkOutput("t3_stall1_valid", s_out_valid, 1'b1);
    checkOutput("t3_stall1_addr", s_out_address, 8'hA1);
    tick();
    checkOutput("t3_stall2_addr", s_out_address, 8'hA1);
    checkOutput("t3_stall2_actual", s_out_actual, 1'b1);
    out_ready = 1'b1; tick();
    checkOutput("t3_e2_addr", s_out_address, 8'hA2);
    checkOutput("t3_e2_actual", s_out_actual, 1'b0);
    tick();
    checkOutput("t3_e3_addr", s_out_address, 8'hA3);
    checkOutput("t3_e3_valid", s_out_valid, 1'b1);
    tick();
    checkOutput("t3_end_valid", s_out_valid, 1'b0);
    checkOutput("t3_done", s_done, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("t3_clr_overflow", s_overflow, 1'b0);
    checkOutput("t3_clr_mispredict", s_mispredict_count, 32'd0);

    // Test 4: drain_req in the same cycle as an accepted capture of 0x7F
    applyStimulus(1'b1, 8'h01, 1'b0, 1'b0); tick();
    applyStimulus(1'b1, 8'h7F, 1'b1, 1'b0);
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t4_entries", s_entries, 3'd2);
    checkOutput("t4_branch", s_branch_count, 32'd2);
    checkOutput("t4_mispredict", s_mispredict_count, 32'd1);
    checkOutput("t4_in_ready", s_in_ready, 1'b0);
    tick();
    tick();
    checkOutput("t4_e0_addr", s_out_address, 8'h01);
    tick();
    checkOutput("t4_e1_payload", {s_out_address, s_out_actual, s_out_predicted}, {8'h7F, 2'b10});
    tick();
    checkOutput("t4_end_valid", s_out_valid, 1'b0);
    checkOutput("t4_done", s_done, 1'b1);
    clear = 1'b1;
    tick();
    clear = 1'b0;

    // Test 5: drain of an empty buffer, then clear
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    checkOutput("t5_lat0_done", s_done, 1'b0);
    checkOutput("t5_lat0_valid", s_out_valid, 1'b0);
    tick();
    checkOutput("t5_done", s_done, 1'b1);
    checkOutput("t5_valid", s_out_valid, 1'b0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checkOutput("t5_clr_in_ready", s_in_ready, 1'b1);
    checkOutput("t5_clr_branch", s_branch_count, 32'd0);
    checkOutput("t5_clr_mispredict", s_mispredict_count, 32'd0);
    checkOutput("t5_clr_done", s_done, 1'b0);

    // Test 6: reset in the middle of draining five entries (default-depth instance)
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 8'h50 + 8'(i), 1'b1, 1'b1);
      tick();
    end
    applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
    checkOutput("t6_entries", b_entries, 11'd5);
    drain_req = 1'b1;
    out_ready = 1'b1;
    tick();
    drain_req = 1'b0;
    tick();
    tick();
    checkOutput("t6_e0_valid", b_out_valid, 1'b1);
    checkOutput("t6_e0_addr", b_out_address, 8'h50);
    tick();
    checkOutput("t6_e1_addr", b_out_address, 8'h51);
    tick();
    checkOutput("t6_e2_addr", b_out_address, 8'h52);
    reset = 1'b0;
    tick();
    checkOutput("t6_rst_valid", b_out_valid, 1'b0);
    checkOutput("t6_rst_entries", b_entries, 11'd0);
    checkOutput("t6_rst_done", b_done, 1'b0);
    checkOutput("t6_rst_branch", b_branch_count, 32'd0);
    checkOutput("t6_rst_in_ready", b_in_ready, 1'b0);
    reset = 1'b1;
    out_ready = 1'b0;
    tick();
    checkOutput("t6_capture_ready", b_in_ready, 1'b1);
    checkOutput("t6_capture_overflow", b_overflow, 1'b0);

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
